spi_bus_arbiter: RTL and testbench

Shares the single 16-bit SPI master (`SPI_mstr`) between two requesters: the inertial sensor interface (port 0) and the A2D interface (port 1). The block sits between the requesters and the master. It does three things:
- grants the bus round-robin, one transaction at a time;
- multiplexes the command and `wrt` strobe to the master;
- routes the master's `SS_n` to the selected device's chip select.

An optional lock lets a requester keep the bus across back-to-back transactions, for example an 8-register read burst. A watchdog aborts transactions whose `done` never arrives.

---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_arb_rr.sv | 25 ++
 rtl/spi_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
// The arbiter top honours lock0/lock1 only when SPI_ARB_LOCK_EN is defined.
package spi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Default watchdog limit, in clk cycles from wrt to master done
  localparam int TO_CYCLES_DEFAULT = 2047;

  // Port numbering: inertial sensor on port 0, A2D on port 1
  localparam logic PORT_INERT = 1'b0;
  localparam logic PORT_A2D   = 1'b1;

endpackage

// File: rtl/spi_arb_rr.sv
// Two-input round-robin picker. Purely combinational.
// A lone requester wins. On a tie, the port that was not granted last wins.
module spi_arb_rr
  import spi_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  // Pick the winner from the current requests and the last grant
  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = PORT_A2D;
    end else begin
      winner = PORT_INERT;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one 16-bit SPI master between two requesters.
// - Grants the bus round-robin, one transaction at a time.
// - Muxes the command and wrt strobe to the master.
// - Steers the master SS_n to the owning device.
// - A watchdog aborts a transaction whose done never arrives.
// Optional feature macro: SPI_ARB_LOCK_EN. When it is defined, a requester
// holding lock and req keeps the bus across back-to-back transactions.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TO_CYCLES = TO_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        tmo,
  output logic        owner,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        mst_done,
  input  logic [15:0] mst_rd_data,
  input  logic        mst_SS_n,
  output logic        SS0_n,
  output logic        SS1_n
);

  localparam int              WD_W     = $clog2(TO_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TO_CYCLES);

  arb_state_t      state_reg, state_next;
  logic            owner_reg, owner_next;
  logic            last_reg, last_next;
  logic [15:0]     cmd_reg, cmd_next;
  logic [WD_W-1:0] wdog_reg, wdog_next;

  logic [1:0]      req_vec;
  logic [1:0]      lock_vec;
  logic [1:0]      ack_vec;
  logic [1:0]      done_vec;
  logic [1:0]      ss_vec;
  logic [15:0]     cmd_vec [2];

  logic            winner;
  logic            any_req;
  logic            relock;
  logic            wd_expired;

  assign req_vec    = {req1, req0};
  assign lock_vec   = {lock1, lock0};
  assign cmd_vec[0] = cmd0;
  assign cmd_vec[1] = cmd1;

  spi_arb_rr u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (last_reg),
    .winner (winner),
    .any    (any_req)
  );

  // The watchdog fires only when it expires without a done in the same cycle
  assign wd_expired = (state_reg == BUSY) && !mst_done && (wdog_reg == WD_LIMIT);

`ifdef SPI_ARB_LOCK_EN
  // The owner keeps the bus when it completes with lock and req both high
  assign relock = mst_done & lock_vec[owner_reg] & req_vec[owner_reg];
`else
  // The lock inputs exist on the port list but have no effect
  logic unused_lock;
  assign unused_lock = ^lock_vec;
  assign relock      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Owner, last grant, command and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg <= PORT_INERT;
      last_reg  <= PORT_A2D;
      cmd_reg   <= 16'h0000;
      wdog_reg  <= '0;
    end else begin
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cmd_reg   <= cmd_next;
      wdog_reg  <= wdog_next;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cmd_next   = cmd_reg;
    wdog_next  = wdog_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          owner_next = winner;
          cmd_next   = cmd_vec[winner];
          state_next = START;
        end
      end
      START: begin
        wdog_next  = '0;
        state_next = BUSY;
      end
      BUSY: begin
        if (mst_done) begin
          last_next = owner_reg;
          if (relock) begin
            cmd_next   = cmd_vec[owner_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else if (wd_expired) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end else if (wdog_reg != WD_LIMIT) begin
          wdog_next = wdog_reg + WD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-state strobes: ack, wrt, done and tmo
  always_comb begin
    wrt      = (state_reg == START);
    tmo      = wd_expired;
    ack_vec  = 2'b00;
    done_vec = 2'b00;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          ack_vec[winner] = 1'b1;
        end
      end
      BUSY: begin
        if (mst_done) begin
          done_vec[owner_reg] = 1'b1;
          if (relock) begin
            ack_vec[owner_reg] = 1'b1;
          end
        end
      end
      default: begin
        ack_vec  = 2'b00;
        done_vec = 2'b00;
      end
    endcase
  end

  // Chip select steering: only the owner sees the master SS_n.
  // Both selects are forced high while reset is asserted.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ss_vec[gi] = (!rst_n || (owner_reg != 1'(gi))) ? 1'b1 : mst_SS_n;
    end
  endgenerate

  assign ack0    = ack_vec[0];
  assign ack1    = ack_vec[1];
  assign done0   = done_vec[0];
  assign done1   = done_vec[1];
  assign SS0_n   = ss_vec[0];
  assign SS1_n   = ss_vec[1];
  assign owner   = owner_reg;
  assign cmd     = cmd_reg;
  assign rd_data = mst_rd_data;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed testbench for spi_bus_arbiter with a short watchdog limit.
// Expectations for the lock scenario follow SPI_ARB_LOCK_EN.
module tb_spi_bus_arbiter;

  localparam int TO = 20;
`ifdef SPI_ARB_LOCK_EN
  localparam bit LOCKED = 1'b1;
`else
  localparam bit LOCKED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock0, lock1;
  logic [15:0] cmd0, cmd1;
  logic        ack0, ack1, done0, done1, tmo, owner, wrt;
  logic [15:0] rd_data, cmd;
  logic        mst_done, mst_SS_n;
  logic [15:0] mst_rd_data;
  logic        SS0_n, SS1_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] nxt_cmd [2];

  always #5 clk = ~clk;

  spi_bus_arbiter #(.TO_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .req1        (req1),
    .cmd0        (cmd0),
    .cmd1        (cmd1),
    .lock0       (lock0),
    .lock1       (lock1),
    .ack0        (ack0),
    .ack1        (ack1),
    .done0       (done0),
    .done1       (done1),
    .rd_data     (rd_data),
    .tmo         (tmo),
    .owner       (owner),
    .wrt         (wrt),
    .cmd         (cmd),
    .mst_done    (mst_done),
    .mst_rd_data (mst_rd_data),
    .mst_SS_n    (mst_SS_n),
    .SS0_n       (SS0_n),
    .SS1_n       (SS1_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete unlocked transaction starting in an IDLE cycle with req set
  task automatic run_txn(input logic p, input logic [15:0] c, input bit drop);
    #1;
    chk("ack", {30'd0, ack1, ack0}, p ? 32'd2 : 32'd1);
    tick();
    if (drop) begin
      if (p) req1 = 1'b0; else req0 = 1'b0;
    end
    #1;
    chk("wrt", {31'd0, wrt}, 32'd1);
    chk("cmd", {16'd0, cmd}, {16'd0, c});
    chk("owner", {31'd0, owner}, {31'd0, p});
    tick();
    mst_SS_n = 1'b0;
    #1;
    chk("wrt_one", {31'd0, wrt}, 32'd0);
    chk("ss", {30'd0, SS1_n, SS0_n}, p ? 32'd1 : 32'd2);
    tick();
    tick();
    mst_done    = 1'b1;
    mst_rd_data = c ^ 16'hFFFF;
    #1;
    chk("done", {30'd0, done1, done0}, p ? 32'd2 : 32'd1);
    chk("rd_data", {16'd0, rd_data}, {16'd0, c ^ 16'hFFFF});
    tick();
    mst_done = 1'b0;
    mst_SS_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic p;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    cmd0 = 16'h0; cmd1 = 16'h0; mst_done = 1'b0; mst_rd_data = 16'h0;
    mst_SS_n = 1'b0;
    #2;
    // Reset values, with the master select low to show the gating
    chk("rst_ss", {30'd0, SS1_n, SS0_n}, 32'd3);
    chk("rst_wrt", {31'd0, wrt}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_strobes", {28'd0, ack1, ack0, done1, done0}, 32'd0);
    chk("rst_tmo", {31'd0, tmo}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mst_SS_n = 1'b1;
    tick();

    // Lone request on port 0
    req0 = 1'b1; cmd0 = 16'hA400;
    run_txn(1'b0, 16'hA400, 1'b1);
    #1;
    chk("lone_ack_after", {30'd0, ack1, ack0}, 32'd0);
    tick();
    chk("lone_idle_wrt", {31'd0, wrt}, 32'd0);

    // Tie under contention: last grant was port 0, so port 1 wins first
    req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h1111; cmd1 = 16'h2222;
    run_txn(1'b1, 16'h2222, 1'b0);
    run_txn(1'b0, 16'h1111, 1'b0);
    run_txn(1'b1, 16'h2222, 1'b0);
    run_txn(1'b0, 16'h1111, 1'b0);
    // Both requests withdrawn before the edge: no transaction
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("drop_ack", {30'd0, ack1, ack0}, 32'd0);
    tick();
    chk("drop_wrt", {31'd0, wrt}, 32'd0);
    tick();
    chk("drop_wrt2", {31'd0, wrt}, 32'd0);

    // Stray master done in IDLE
    mst_done = 1'b1;
    #1;
    chk("stray_done", {30'd0, done1, done0}, 32'd0);
    chk("stray_tmo", {31'd0, tmo}, 32'd0);
    tick();
    mst_done = 1'b0;
    #1;
    chk("stray_wrt", {31'd0, wrt}, 32'd0);
    req1 = 1'b1; cmd1 = 16'hBEEF;
    run_txn(1'b1, 16'hBEEF, 1'b1);

    // Watchdog: master never finishes
    req0 = 1'b1; cmd0 = 16'h5555;
    #1;
    chk("wd_ack", {30'd0, ack1, ack0}, 32'd1);
    tick();
    req0 = 1'b0;
    #1;
    chk("wd_wrt", {31'd0, wrt}, 32'd1);
    tick();
    for (int k = 0; k < TO; k++) begin
      chk("wd_early", {31'd0, tmo}, 32'd0);
      tick();
    end
    chk("wd_tmo", {31'd0, tmo}, 32'd1);
    chk("wd_nodone", {30'd0, done1, done0}, 32'd0);
    tick();
    chk("wd_tmo_one", {31'd0, tmo}, 32'd0);
    req0 = 1'b1;
    run_txn(1'b0, 16'h5555, 1'b1);

    // Reset in the middle of a transaction
    req1 = 1'b1; cmd1 = 16'h7777;
    #1;
    chk("mr_ack", {30'd0, ack1, ack0}, 32'd2);
    tick();
    req1 = 1'b0;
    #1;
    chk("mr_cmd", {16'd0, cmd}, 32'h7777);
    tick();
    mst_SS_n = 1'b0;
    #1;
    chk("mr_ss_busy", {30'd0, SS1_n, SS0_n}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_ss", {30'd0, SS1_n, SS0_n}, 32'd3);
    chk("mr_wrt", {31'd0, wrt}, 32'd0);
    chk("mr_cmd0", {16'd0, cmd}, 32'd0);
    chk("mr_owner", {31'd0, owner}, 32'd0);
    tick();
    rst_n = 1'b1;
    mst_SS_n = 1'b1;

    // Lock scenario: tie after reset goes to port 0 first
    nxt_cmd[0] = 16'hC000; nxt_cmd[1] = 16'hD000;
    cmd0 = 16'hC000; cmd1 = 16'hD000;
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = LOCKED ? 1'b0 : 1'(i % 2);
      #1;
      if (i == 0 || !LOCKED) begin
        chk("lk_ack", {30'd0, ack1, ack0}, p ? 32'd2 : 32'd1);
        chk("lk_idle_wrt", {31'd0, wrt}, 32'd0);
        tick();
      end
      chk("lk_wrt", {31'd0, wrt}, 32'd1);
      chk("lk_cmd", {16'd0, cmd}, {16'd0, nxt_cmd[p]});
      chk("lk_owner", {31'd0, owner}, {31'd0, p});
      tick();
      tick();
      tick();
      if (i == 7) lock0 = 1'b0;
      nxt_cmd[p] = (p ? 16'hD000 : 16'hC000) + 16'(i + 1);
      if (p) cmd1 = nxt_cmd[1]; else cmd0 = nxt_cmd[0];
      mst_done = 1'b1;
      mst_rd_data = 16'h0100 + 16'(i);
      #1;
      chk("lk_done", {30'd0, done1, done0}, p ? 32'd2 : 32'd1);
      chk("lk_rd", {16'd0, rd_data}, {16'd0, 16'h0100 + 16'(i)});
      chk("lk_reack", {30'd0, ack1, ack0}, (LOCKED && i < 7) ? 32'd1 : 32'd0);
      tick();
      mst_done = 1'b0;
    end
    #1;
    chk("lk_final_ack", {30'd0, ack1, ack0}, LOCKED ? 32'd2 : 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("lk_final_wrt", {31'd0, wrt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
